mskmc_col_sched: RTL and testbench

Sequences masked AES MixColumns one column per cycle for the 32-bit serial datapath. It accepts a masked 4-byte column over a valid/ready handshake and applies MixColumns sharewise using four xtime/x3 product units. The column count and per-state bypass are tracked so that final-round columns pass through untouched. It sits between the ShiftRows byte router and the AddRoundKey stage.

---
 rtl/mskmc_col_sched.sv | 108 ++++++++++
 tb/tb_mskmc_col_sched.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mskmc_col_sched.sv
// Masked MixColumns column sequencer: one column per cycle, sharewise GF(2^8) arithmetic,
// single output register stage with valid/ready and per-state final-round bypass.
module mskmc_col_sched #(
    parameter int unsigned d = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [32*d-1:0] in_col,
    input  logic            in_last_round,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [32*d-1:0] out_col,
    output logic [1:0]      out_idx,
    output logic            out_last_col,
    output logic            out_bypassed
);

    localparam int unsigned W = 32 * d;

    typedef enum logic {StIdle, StActive} state_e;

    state_e         state_q;
    logic [1:0]     col_cnt_q;
    logic           byp_q;
    logic           out_valid_q;
    logic [W-1:0]   out_col_q;
    logic [1:0]     out_idx_q;
    logic           out_last_q;
    logic           out_byp_q;

    logic           accept;
    logic           byp_now;
    logic [W-1:0]   mix_col;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Each share is mixed on its own; bytes of different shares never meet.
    function automatic logic [W-1:0] mix_masked(input logic [W-1:0] col);
        logic [3:0][7:0] a;
        logic [3:0][7:0] b;
        logic [W-1:0]    res;
        res = '0;
        for (int j = 0; j < int'(d); j++) begin
            for (int k = 0; k < 4; k++) begin
                for (int i = 0; i < 8; i++) begin
                    a[k][i] = col[k*8*int'(d) + i*int'(d) + j];
                end
            end
            for (int k = 0; k < 4; k++) begin
                b[k] = xtime(a[k]) ^ xtime(a[(k+1)%4]) ^ a[(k+1)%4]
                     ^ a[(k+2)%4] ^ a[(k+3)%4];
            end
            for (int k = 0; k < 4; k++) begin
                for (int i = 0; i < 8; i++) begin
                    res[k*8*int'(d) + i*int'(d) + j] = b[k][i];
                end
            end
        end
        return res;
    endfunction

    assign mix_col  = mix_masked(in_col);
    assign in_ready = ~out_valid_q | out_ready;
    assign accept   = in_valid & in_ready;
    // The bypass decision is sampled only at the first column of a state.
    assign byp_now  = (state_q == StIdle) ? in_last_round : byp_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            col_cnt_q   <= 2'd0;
            byp_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_col_q   <= '0;
            out_idx_q   <= 2'd0;
            out_last_q  <= 1'b0;
            out_byp_q   <= 1'b0;
        end else begin
            if (accept) begin
                out_col_q   <= byp_now ? in_col : mix_col;
                out_idx_q   <= col_cnt_q;
                out_last_q  <= (col_cnt_q == 2'd3);
                out_byp_q   <= byp_now;
                out_valid_q <= 1'b1;
                byp_q       <= byp_now;
                col_cnt_q   <= col_cnt_q + 2'd1;
                unique case (state_q)
                    StIdle:   state_q <= StActive;
                    StActive: if (col_cnt_q == 2'd3) state_q <= StIdle;
                    default:  state_q <= StIdle;
                endcase
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid    = out_valid_q;
    assign out_col      = out_col_q;
    assign out_idx      = out_idx_q;
    assign out_last_col = out_last_q;
    assign out_bypassed = out_byp_q;

endmodule

// File: tb/tb_mskmc_col_sched.sv
// Bench for mskmc_col_sched: d=2 and d=3 instances driven in lockstep with the same
// recombined columns, checked every cycle against a GF(2^8) matrix-multiply model.
module tb_mskmc_col_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid = 1'b0;
    logic        in_last_round = 1'b0;
    logic        out_ready = 1'b1;
    logic        rand_ready = 1'b0;
    logic [63:0] in_col2 = '0;
    logic [95:0] in_col3 = '0;
    logic [31:0] plain_in = '0;

    logic        in_ready2, out_valid2, out_last2, out_byp2;
    logic [63:0] out_col2;
    logic [1:0]  out_idx2;
    logic        in_ready3, out_valid3, out_last3, out_byp3;
    logic [95:0] out_col3;
    logic [1:0]  out_idx3;

    int checks = 0;
    int failures = 0;

    mskmc_col_sched #(.d(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .in_col(in_col2), .in_last_round(in_last_round), .out_valid(out_valid2),
        .out_ready(out_ready), .out_col(out_col2), .out_idx(out_idx2),
        .out_last_col(out_last2), .out_bypassed(out_byp2)
    );

    mskmc_col_sched #(.d(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready3),
        .in_col(in_col3), .in_last_round(in_last_round), .out_valid(out_valid3),
        .out_ready(out_ready), .out_col(out_col3), .out_idx(out_idx3),
        .out_last_col(out_last3), .out_bypassed(out_byp3)
    );

    // ---------------- reference arithmetic ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int n = 0; n < 8; n++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] coef(input int c);
        case (c)
            0: return 8'h02;
            1: return 8'h03;
            default: return 8'h01;
        endcase
    endfunction

    // Plain column as big-endian word: row 0 in the top byte.
    function automatic logic [31:0] gold(input logic [31:0] p);
        logic [31:0] r = '0;
        for (int row = 0; row < 4; row++) begin
            logic [7:0] acc = 8'h00;
            for (int k = 0; k < 4; k++) acc = acc ^ gmul(coef((k - row + 4) % 4), p[31-8*k -: 8]);
            r[31-8*row -: 8] = acc;
        end
        return r;
    endfunction

    function automatic logic [95:0] split(input logic [31:0] p, input int dd);
        logic [95:0] v = '0;
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < 8; i++) begin
                logic x = p[24-8*k+i];
                for (int j = 0; j < dd - 1; j++) begin
                    logic r = 1'($urandom_range(0, 1));
                    v[k*8*dd + i*dd + j] = r;
                    x = x ^ r;
                end
                v[k*8*dd + i*dd + dd - 1] = x;
            end
        return v;
    endfunction

    function automatic logic [31:0] share_of(input logic [95:0] v, input int dd, input int j);
        logic [31:0] p = '0;
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < 8; i++) p[24-8*k+i] = v[k*8*dd + i*dd + j];
        return p;
    endfunction

    function automatic logic [31:0] recombine(input logic [95:0] v, input int dd);
        logic [31:0] p = '0;
        for (int j = 0; j < dd; j++) p = p ^ share_of(v, dd, j);
        return p;
    endfunction

    function automatic logic [95:0] model_col(input logic [95:0] v, input int dd, input logic byp);
        logic [95:0] r = '0;
        if (byp) return v;
        for (int j = 0; j < dd; j++) begin
            logic [31:0] s = gold(share_of(v, dd, j));
            for (int k = 0; k < 4; k++)
                for (int i = 0; i < 8; i++) r[k*8*dd + i*dd + j] = s[24-8*k+i];
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    int          n_acc;
    logic        mv, mbyp, m_last, m_byp;
    logic [1:0]  m_idx;
    logic [63:0] m_col2;
    logic [95:0] m_col3;
    logic [31:0] m_plain;
    logic        m_acc, m_byp_now;

    assign m_acc     = in_valid && (!mv || out_ready);
    assign m_byp_now = (n_acc % 4 == 0) ? in_last_round : mbyp;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_acc <= 0; mv <= 1'b0; mbyp <= 1'b0; m_last <= 1'b0; m_byp <= 1'b0;
            m_idx <= 2'd0; m_col2 <= '0; m_col3 <= '0; m_plain <= '0;
        end else if (m_acc) begin
            mv      <= 1'b1;
            m_idx   <= 2'(n_acc % 4);
            m_last  <= (n_acc % 4 == 3);
            m_byp   <= m_byp_now;
            mbyp    <= m_byp_now;
            m_col2  <= 64'(model_col(96'(in_col2), 2, m_byp_now));
            m_col3  <= model_col(in_col3, 3, m_byp_now);
            m_plain <= m_byp_now ? plain_in : gold(plain_in);
            n_acc   <= n_acc + 1;
        end else if (out_ready) begin
            mv <= 1'b0;
        end
    end

    always @(negedge clk) begin
        chk("in_ready2", 96'(in_ready2), 96'(!mv || out_ready));
        chk("in_ready3", 96'(in_ready3), 96'(!mv || out_ready));
        chk("out_valid2", 96'(out_valid2), 96'(mv));
        chk("out_valid3", 96'(out_valid3), 96'(mv));
        chk("out_col2", 96'(out_col2), 96'(m_col2));
        chk("out_col3", out_col3, m_col3);
        chk("out_idx", 96'({out_idx2, out_idx3}), 96'({m_idx, m_idx}));
        chk("out_last", 96'({out_last2, out_last3}), 96'({m_last, m_last}));
        chk("out_byp", 96'({out_byp2, out_byp3}), 96'({m_byp, m_byp}));
        if (mv) begin
            chk("recomb2", 96'(recombine(96'(out_col2), 2)), 96'(m_plain));
            chk("recomb3", 96'(recombine(out_col3, 3)), 96'(m_plain));
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic [31:0] p, input logic lr);
        plain_in      = p;
        in_col2       = 64'(split(p, 2));
        in_col3       = split(p, 3);
        in_last_round = lr;
        in_valid      = 1'b1;
    endtask

    task automatic send(input logic [31:0] p, input logic lr);
        int   n = 0;
        logic rdy;
        drive(p, lr);
        do begin
            @(negedge clk);
            rdy = in_ready3;
            @(posedge clk);
            #1;
            n++;
        end while (!rdy && n < 200);
        if (!rdy) begin
            checks++; failures++;
            $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", n);
        end
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    logic [95:0] saved3;

    initial begin
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        chk("gold_v0", 96'(gold(32'hdb135345)), 96'(32'h8e4da1bc));
        chk("gold_v1", 96'(gold(32'hd4bf5d30)), 96'(32'h046681e5));
        chk("gold_v2", 96'(gold(32'h01010101)), 96'(32'h01010101));
        chk("gold_v3", 96'(gold(32'hc6c6c6c6)), 96'(32'hc6c6c6c6));
        idle(2);
        rst_n = 1'b1;
        idle(1);

        // Single column, normal round.
        send(32'hdb135345, 1'b0);
        @(negedge clk);
        chk("t1_valid", 96'(out_valid2), 96'(1));
        chk("t1_col", 96'(recombine(96'(out_col2), 2)), 96'(32'h8e4da1bc));
        chk("t1_idx", 96'(out_idx2), 96'(0));
        chk("t1_byp", 96'(out_byp2), 96'(0));
        @(posedge clk); #1;
        for (int c = 0; c < 3; c++) send($urandom, 1'b0);

        // Four back-to-back columns.
        send(32'hd4bf5d30, 1'b0);
        send(32'h01010101, 1'b1);
        send(32'hc6c6c6c6, 1'b1);
        send(32'hdb135345, 1'b1);
        @(negedge clk);
        chk("t2_col", 96'(recombine(out_col3, 3)), 96'(32'h8e4da1bc));
        chk("t2_idx", 96'(out_idx3), 96'(3));
        chk("t2_last", 96'(out_last3), 96'(1));
        @(posedge clk); #1;

        // Final-round bypass state, then a normal state.
        send(32'h3243f6a8, 1'b1);
        saved3 = in_col3;
        @(negedge clk);
        chk("t3_byp", 96'(out_byp3), 96'(1));
        chk("t3_col", out_col3, saved3);
        @(posedge clk); #1;
        for (int c = 0; c < 3; c++) send($urandom, 1'b0);
        for (int c = 0; c < 4; c++) send($urandom, 1'b0);

        // Downstream stall of five cycles, then release with no bubble.
        idle(1);
        out_ready = 1'b0;
        send($urandom, 1'b0);
        drive($urandom, 1'b1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("t4_in_ready", 96'(in_ready3), 96'(0));
            chk("t4_valid", 96'(out_valid3), 96'(1));
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        send(plain_in, 1'b1);
        send($urandom, 1'b0);
        send($urandom, 1'b0);

        // Asynchronous reset mid-state.
        send($urandom, 1'b0);
        send($urandom, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("t5_valid", 96'({out_valid2, out_valid3}), 96'(0));
        chk("t5_col", out_col3 | 96'(out_col2), 96'(0));
        chk("t5_idx", 96'({out_idx2, out_idx3, out_last3, out_byp3}), 96'(0));
        idle(2);
        rst_n = 1'b1;
        idle(1);
        send($urandom, 1'b1);
        @(negedge clk);
        chk("t5_idx0", 96'(out_idx3), 96'(0));
        chk("t5_byp", 96'(out_byp3), 96'(1));
        @(posedge clk); #1;
        for (int c = 0; c < 3; c++) send($urandom, 1'b0);

        // Random regression with valid gaps and ready stalls.
        rand_ready = 1'b1;
        for (int c = 0; c < 1000; c++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            send($urandom, 1'($urandom_range(0, 1)));
        end
        rand_ready = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
